// File: rtl/alu_cmd_pkg.sv
// Shared encodings for the ID stage: ALU CMD codes, MIPS opcode/funct values,
// branch-type codes and the decoded-instruction bundle.
package alu_cmd_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned BR_W   = 2;

    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_OR  = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_NOR = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_XOR = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_SLL = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_SRA = 4'b1001;
    localparam logic [CMD_W-1:0] CMD_SRL = 4'b1010;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    localparam logic [BR_W-1:0] BR_NONE = 2'b00;
    localparam logic [BR_W-1:0] BR_BEQ  = 2'b01;
    localparam logic [BR_W-1:0] BR_BNE  = 2'b10;
    localparam logic [BR_W-1:0] BR_J    = 2'b11;

    typedef struct packed {
        logic [CMD_W-1:0]  exe_cmd;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic [DATA_W-1:0] st_val;
        logic [REG_W-1:0]  dest;
        logic              wb_en;
        logic              mem_r;
        logic              mem_w;
        logic [BR_W-1:0]   br_type;
        logic [DATA_W-1:0] br_imm;
        logic              illegal;
    } dec_t;

endpackage

// File: rtl/id_decode_comb.sv
// Combinational MIPS decoder: instruction + register read data -> ALU/MEM/WB control bundle.
module id_decode_comb
    import alu_cmd_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output dec_t              dec
);

    logic [5:0]        w_op;
    logic [5:0]        w_fn;
    logic [REG_W-1:0]  w_rt;
    logic [REG_W-1:0]  w_rd;
    logic [REG_W-1:0]  w_shamt;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_imm_zext;

    assign w_op       = instr[31:26];
    assign w_fn       = instr[5:0];
    assign w_rt       = instr[20:16];
    assign w_rd       = instr[15:11];
    assign w_shamt    = instr[10:6];
    assign w_imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign w_imm_zext = {16'b0, instr[15:0]};

    always_comb begin
        dec         = '0;
        dec.exe_cmd = CMD_ADD;
        dec.st_val  = rt_data;
        dec.br_imm  = (w_op == OP_J) ? {6'b0, instr[25:0]} : w_imm_sext;

        case (w_op)
            OP_RTYPE: begin
                dec.dest  = w_rd;
                dec.wb_en = 1'b1;
                dec.val_a = rs_data;
                dec.val_b = rt_data;
                case (w_fn)
                    FN_ADD:  dec.exe_cmd = CMD_ADD;
                    FN_SUB:  dec.exe_cmd = CMD_SUB;
                    FN_AND:  dec.exe_cmd = CMD_AND;
                    FN_OR:   dec.exe_cmd = CMD_OR;
                    FN_XOR:  dec.exe_cmd = CMD_XOR;
                    FN_NOR:  dec.exe_cmd = CMD_NOR;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec.val_a = rt_data;
                        dec.val_b = {27'b0, w_shamt};
                        dec.exe_cmd = (w_fn == FN_SLL) ? CMD_SLL :
                                      (w_fn == FN_SRL) ? CMD_SRL : CMD_SRA;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        dec.val_a = rt_data;
                        dec.val_b = {27'b0, rs_data[4:0]};
                        dec.exe_cmd = (w_fn == FN_SLLV) ? CMD_SLL :
                                      (w_fn == FN_SRLV) ? CMD_SRL : CMD_SRA;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                dec.dest  = w_rt;
                dec.wb_en = 1'b1;
                dec.val_a = rs_data;
                dec.val_b = (w_op == OP_ADDI || w_op == OP_LW) ? w_imm_sext : w_imm_zext;
                dec.mem_r = (w_op == OP_LW);
                dec.exe_cmd = (w_op == OP_ANDI) ? CMD_AND :
                              (w_op == OP_ORI)  ? CMD_OR  :
                              (w_op == OP_XORI) ? CMD_XOR : CMD_ADD;
            end
            OP_SW: begin
                dec.val_a = rs_data;
                dec.val_b = w_imm_sext;
                dec.mem_w = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.exe_cmd = CMD_SUB;
                dec.val_a   = rs_data;
                dec.val_b   = rt_data;
                dec.br_type = (w_op == OP_BEQ) ? BR_BEQ : BR_BNE;
            end
            OP_J:    dec.br_type = BR_J;
            default: dec.illegal = 1'b1;
        endcase

        // Writes to $0 are dropped, which makes the all-zero word a NOP.
        if (dec.dest == '0) dec.wb_en = 1'b0;

        if (dec.illegal) begin
            dec.exe_cmd = CMD_ADD;
            dec.val_a   = '0;
            dec.val_b   = '0;
            dec.dest    = '0;
            dec.wb_en   = 1'b0;
            dec.mem_r   = 1'b0;
            dec.mem_w   = 1'b0;
            dec.br_type = BR_NONE;
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// ID pipeline stage: registers the decoded instruction with valid/ready toward EXE,
// branch flush, and a saturating count of accepted illegal instructions.
module id_decode_stage
    import alu_cmd_pkg::*;
#(
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    instr,
    input  logic [DATA_W-1:0]    pc_in,
    input  logic [DATA_W-1:0]    rs_data,
    input  logic [DATA_W-1:0]    rt_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CMD_W-1:0]     exe_cmd,
    output logic [DATA_W-1:0]    val_a,
    output logic [DATA_W-1:0]    val_b,
    output logic [DATA_W-1:0]    st_val,
    output logic [REG_W-1:0]     dest,
    output logic                 wb_en,
    output logic                 mem_r,
    output logic                 mem_w,
    output logic [BR_W-1:0]      br_type,
    output logic [DATA_W-1:0]    br_imm,
    output logic [DATA_W-1:0]    pc_out,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegal_cnt
);

    dec_t                 w_dec;
    dec_t                 r_dec;
    logic [DATA_W-1:0]    r_pc;
    logic                 r_out_valid;
    logic [ILL_CNT_W-1:0] r_ill_cnt;
    logic                 w_load;

    id_decode_comb u_dec (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .dec     (w_dec)
    );

    assign in_ready = !r_out_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    // Pipeline register: flush kills, load replaces, otherwise drain or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dec       <= '0;
            r_pc        <= '0;
            r_out_valid <= 1'b0;
            r_ill_cnt   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_dec       <= w_dec;
            r_pc        <= pc_in;
            r_out_valid <= 1'b1;
            if (w_dec.illegal && (r_ill_cnt != '1))
                r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign exe_cmd     = r_dec.exe_cmd;
    assign val_a       = r_dec.val_a;
    assign val_b       = r_dec.val_b;
    assign st_val      = r_dec.st_val;
    assign dest        = r_dec.dest;
    assign wb_en       = r_dec.wb_en;
    assign mem_r       = r_dec.mem_r;
    assign mem_w       = r_dec.mem_w;
    assign br_type     = r_dec.br_type;
    assign br_imm      = r_dec.br_imm;
    assign pc_out      = r_pc;
    assign illegal     = r_dec.illegal;
    assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: expected decodes are queued at drive time
// and compared field by field when the registered output appears.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  exe_cmd;
    logic [31:0] val_a;
    logic [31:0] val_b;
    logic [31:0] st_val;
    logic [4:0]  dest;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
    logic [1:0]  br_type;
    logic [31:0] br_imm;
    logic [31:0] pc_out;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    id_decode_stage #(.ILL_CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc_in       (pc_in),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .exe_cmd     (exe_cmd),
        .val_a       (val_a),
        .val_b       (val_b),
        .st_val      (st_val),
        .dest        (dest),
        .wb_en       (wb_en),
        .mem_r       (mem_r),
        .mem_w       (mem_w),
        .br_type     (br_type),
        .br_imm      (br_imm),
        .pc_out      (pc_out),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        wb;
        logic        mr;
        logic        mw;
        logic [1:0]  br;
        logic        ill;
        logic [31:0] pc;
        bit          chk_st;
        logic [31:0] st;
        bit          chk_bimm;
        logic [31:0] bimm;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] pc_ctr = 32'h0000_1004;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] d, input logic wb, input logic mr, input logic mw,
                                input logic [1:0] br, input logic ill);
        exp_t e;
        e.cmd = cmd; e.a = a; e.b = b; e.dest = d; e.wb = wb; e.mr = mr; e.mw = mw;
        e.br = br; e.ill = ill; e.pc = '0;
        e.chk_st = 1'b0; e.st = '0; e.chk_bimm = 1'b0; e.bimm = '0;
        return e;
    endfunction

    task automatic cmp_fields(input string tag, input exp_t e);
        check({tag, ".vld"},  32'(out_valid), 32'd1);
        check({tag, ".cmd"},  32'(exe_cmd),   32'(e.cmd));
        check({tag, ".a"},    val_a,          e.a);
        check({tag, ".b"},    val_b,          e.b);
        check({tag, ".dest"}, 32'(dest),      32'(e.dest));
        check({tag, ".wb"},   32'(wb_en),     32'(e.wb));
        check({tag, ".mr"},   32'(mem_r),     32'(e.mr));
        check({tag, ".mw"},   32'(mem_w),     32'(e.mw));
        check({tag, ".br"},   32'(br_type),   32'(e.br));
        check({tag, ".ill"},  32'(illegal),   32'(e.ill));
        check({tag, ".pc"},   pc_out,         e.pc);
        if (e.chk_st)   check({tag, ".st"},   st_val, e.st);
        if (e.chk_bimm) check({tag, ".bimm"}, br_imm, e.bimm);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL %s observed=output expected=empty-scoreboard", tag);
        end else begin
            e = sb.pop_front();
            cmp_fields(tag, e);
        end
    endtask

    // Drive one instruction for a single cycle with EXE ready, then check it.
    task automatic send(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input exp_t e);
        instr = ins; rs_data = rs; rt_data = rt; pc_in = pc_ctr;
        e.pc = pc_ctr; pc_ctr += 32'd4;
        in_valid = 1'b1; out_ready = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        pop_check(tag);
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".vld"},  32'(out_valid),   32'd0);
        check({tag, ".rdy"},  32'(in_ready),    32'd1);
        check({tag, ".cnt"},  32'(illegal_cnt), 32'd0);
        check({tag, ".ill"},  32'(illegal),     32'd0);
        check({tag, ".cmd"},  32'(exe_cmd),     32'd0);
        check({tag, ".a"},    val_a,            32'd0);
        check({tag, ".b"},    val_b,            32'd0);
        check({tag, ".dest"}, 32'(dest),        32'd0);
        check({tag, ".wb"},   32'(wb_en),       32'd0);
        check({tag, ".pc"},   pc_out,           32'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        instr = '0; pc_in = '0; rs_data = '0; rt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        idle();

        send("add", 32'h0022_1820, 32'd5, 32'd7, mk(4'b0000, 32'd5, 32'd7, 5'd3, 1, 0, 0, 2'b00, 0));
        send("sra", 32'h0002_20C3, 32'h1234, 32'h8000_0000,
             mk(4'b1001, 32'h8000_0000, 32'd3, 5'd4, 1, 0, 0, 2'b00, 0));
        send("addi", 32'h2025_FFFF, 32'd10, 32'd0,
             mk(4'b0000, 32'd10, 32'hFFFF_FFFF, 5'd5, 1, 0, 0, 2'b00, 0));
        send("andi", 32'h3025_FFFF, 32'h00F0_F0F0, 32'd0,
             mk(4'b0100, 32'h00F0_F0F0, 32'h0000_FFFF, 5'd5, 1, 0, 0, 2'b00, 0));
        send("srlv", 32'h0149_4006, 32'h0000_0025, 32'hF000_0000,
             mk(4'b1010, 32'hF000_0000, 32'd5, 5'd8, 1, 0, 0, 2'b00, 0));
        send("nor", 32'h0064_1027, 32'hAAAA_0000, 32'h0000_5555,
             mk(4'b0110, 32'hAAAA_0000, 32'h0000_5555, 5'd2, 1, 0, 0, 2'b00, 0));
        send("lw", 32'h8C26_0008, 32'h100, 32'h0,
             mk(4'b0000, 32'h100, 32'd8, 5'd6, 1, 1, 0, 2'b00, 0));
        e = mk(4'b0000, 32'h200, 32'hFFFF_FFFC, 5'd0, 0, 0, 1, 2'b00, 0);
        e.dest = dest;
        e = mk(4'b0000, 32'h200, 32'hFFFF_FFFC, 5'd0, 0, 0, 1, 2'b00, 0);
        e.chk_st = 1'b1; e.st = 32'hDEAD_BEEF;
        instr = 32'hAC27_FFFC; rs_data = 32'h200; rt_data = 32'hDEAD_BEEF; pc_in = pc_ctr;
        e.pc = pc_ctr; pc_ctr += 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        check("sw.cmd", 32'(exe_cmd), 32'(e.cmd));
        check("sw.b",   val_b, e.b);
        check("sw.wb",  32'(wb_en), 32'd0);
        check("sw.mw",  32'(mem_w), 32'd1);
        check("sw.mr",  32'(mem_r), 32'd0);
        check("sw.st",  st_val, e.st);

        e = mk(4'b0010, 32'd9, 32'd9, 5'd0, 0, 0, 0, 2'b01, 0);
        e.chk_bimm = 1'b1; e.bimm = 32'hFFFF_FFFE;
        send("beq", 32'h1022_FFFE, 32'd9, 32'd9, e);
        e = mk(4'b0010, 32'd1, 32'd2, 5'd0, 0, 0, 0, 2'b10, 0);
        e.chk_bimm = 1'b1; e.bimm = 32'h0000_0005;
        send("bne", 32'h1422_0005, 32'd1, 32'd2, e);
        e = mk(4'b0000, 32'd0, 32'd0, 5'd0, 0, 0, 0, 2'b11, 0);
        e.chk_bimm = 1'b1; e.bimm = 32'h0012_3456;
        send("j", 32'h0812_3456, 32'h55, 32'h66, e);
        send("nop", 32'h0000_0000, 32'h0, 32'h11, mk(4'b1000, 32'h11, 32'd0, 5'd0, 0, 0, 0, 2'b00, 0));
        send("add_r0", 32'h0022_0020, 32'd1, 32'd2, mk(4'b0000, 32'd1, 32'd2, 5'd0, 0, 0, 0, 2'b00, 0));

        // Stall: output must hold while EXE is not ready, then flush kills it.
        idle();
        instr = 32'h0022_1820; rs_data = 32'd5; rt_data = 32'd7; pc_in = pc_ctr;
        e = mk(4'b0000, 32'd5, 32'd7, 5'd3, 1, 0, 0, 2'b00, 0);
        e.pc = pc_ctr; pc_ctr += 32'd4;
        sb.push_back(e);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        cmp_fields("stall0", sb[0]);
        instr = 32'h3025_FFFF; rs_data = 32'h77; rt_data = 32'h88; pc_in = 32'hBAD0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall.rdy", 32'(in_ready), 32'd0);
            cmp_fields("stall", sb[0]);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush.vld", 32'(out_valid), 32'd0);
        sb.delete(0);

        // Flushed illegal instruction is not counted.
        out_ready = 1'b1; instr = 32'hFC00_0000; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_ill.vld", 32'(out_valid), 32'd0);
        check("flush_ill.cnt", 32'(illegal_cnt), 32'd0);

        // Back-to-back illegal stream; counter saturates at 255.
        instr = 32'hFC00_0000; rs_data = 32'h1; rt_data = 32'h2; out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pc_in = pc_ctr;
            e = mk(4'b0000, 32'd0, 32'd0, 5'd0, 0, 0, 0, 2'b00, 1);
            e.pc = pc_ctr; pc_ctr += 32'd4;
            sb.push_back(e);
            @(posedge clk); #1;
            pop_check("illegal");
            check("ill_cnt", 32'(illegal_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        in_valid = 1'b0;
        send("legal_after", 32'h0022_1820, 32'd3, 32'd4, mk(4'b0000, 32'd3, 32'd4, 5'd3, 1, 0, 0, 2'b00, 0));
        check("cnt_sat_hold", 32'(illegal_cnt), 32'd255);

        // Asynchronous reset during a stall discards the held instruction.
        idle();
        instr = 32'h0022_1820; rs_data = 32'd5; rt_data = 32'd7; pc_in = pc_ctr;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst.vld", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_zero("mid_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        send("post_rst", 32'h0022_1820, 32'd5, 32'd7, mk(4'b0000, 32'd5, 32'd7, 5'd3, 1, 0, 0, 2'b00, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
